pixel_stream_proc: RTL

PIXEL_STREAM_PROC -- requirements
Module: pixel_stream_proc

---
 rtl/pixel_stream_pkg.sv | 26 ++
 rtl/pixel_op.sv | 35 +++
 rtl/pixel_stream_proc.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/pixel_stream_pkg.sv
// -----------------------------------------------------------------------------
// pixel_stream_pkg
// Shared definitions for the pixel stream processor: FSM state encoding,
// pixel-mode codes and the header reserved-bit mask.
// No ports (package).
// -----------------------------------------------------------------------------
package pixel_stream_pkg;

   typedef enum logic [2:0] {
      ST_HDR = 3'd0,   // waiting for a header word
      ST_LEN = 3'd1,   // waiting for the length word
      ST_PIX = 3'd2,   // waiting for a pixel word
      ST_OUT = 3'd3,   // pushing the processed pixel
      ST_SUM = 3'd4    // pushing the frame checksum
   } state_t;

   localparam logic [1:0] MODE_PASS = 2'b00;  // pass-through
   localparam logic [1:0] MODE_INC  = 2'b01;  // saturating +1
   localparam logic [1:0] MODE_INV  = 2'b10;  // bitwise invert
   localparam logic [1:0] MODE_THR  = 2'b11;  // threshold to all-ones / zero

   // Header bits above the mode field must be zero. Wide enough for any
   // DATA_W up to 64; users slice off the low DATA_W bits.
   localparam logic [63:0] HDR_RSVD_MASK = ~64'h3;

endpackage

// File: rtl/pixel_op.sv
// -----------------------------------------------------------------------------
// pixel_op
// Combinational per-pixel transform selected by a 2-bit mode.
// Ports:
//   mode  in  2       transform select (MODE_* codes)
//   x     in  DATA_W  input pixel
//   y     out DATA_W  transformed pixel
// -----------------------------------------------------------------------------
module pixel_op
   import pixel_stream_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int THRESH = 128
) (
   input  logic [1:0]        mode,
   input  logic [DATA_W-1:0] x,
   output logic [DATA_W-1:0] y
);

   localparam logic [DATA_W-1:0] THR = DATA_W'(THRESH);
   localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

   always_comb begin
      y = x;
      case (mode)
         MODE_PASS: y = x;
         // all-ones must not wrap to zero
         MODE_INC:  y = (&x) ? x : x + ONE;
         MODE_INV:  y = ~x;
         MODE_THR:  y = (x >= THR) ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
         default:   y = x;
      endcase
   end

endmodule

// File: rtl/pixel_stream_proc.sv
// -----------------------------------------------------------------------------
// pixel_stream_proc
// Reads framed pixel data from a receive FIFO (header, length N, N pixels),
// transforms each pixel according to the header mode, writes the N results
// to a transmit FIFO and closes each frame with a modulo-2^DATA_W checksum of
// the transmitted pixels.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   en         in   processing enable; low freezes everything
//   rx_empty   in   receive FIFO empty
//   r_data     in   receive FIFO head word
//   rd_uart    out  one-cycle pop strobe to the receive FIFO
//   tx_full    in   transmit FIFO full
//   w_data     out  transmit word (registered)
//   wr_uart    out  one-cycle push strobe to the transmit FIFO
//   busy       out  high in any state other than HDR
//   mode       out  mode latched from the current or last good header
//   frame_cnt  out  completed frames, wrapping
//   err        out  sticky bad-header flag
// -----------------------------------------------------------------------------
module pixel_stream_proc
   import pixel_stream_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int THRESH = 128,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              rx_empty,
   input  logic [DATA_W-1:0] r_data,
   output logic              rd_uart,
   input  logic              tx_full,
   output logic [DATA_W-1:0] w_data,
   output logic              wr_uart,
   output logic              busy,
   output logic [1:0]        mode,
   output logic [CNT_W-1:0]  frame_cnt,
   output logic              err
);

   // One extra bit so a length word of 0 can stand for 2^DATA_W pixels.
   localparam int CW = DATA_W + 1;
   localparam logic [DATA_W-1:0] RSVD = HDR_RSVD_MASK[DATA_W-1:0];

   state_t             state_reg,     state_next;
   logic [1:0]         mode_reg,      mode_next;
   logic [CW-1:0]      cnt_reg,       cnt_next;
   logic [DATA_W-1:0]  csum_reg,      csum_next;
   logic [DATA_W-1:0]  w_data_reg,    w_data_next;
   logic [CNT_W-1:0]   frame_cnt_reg, frame_cnt_next;
   logic               err_reg,       err_next;
   logic [DATA_W-1:0]  pix_y;
   logic [DATA_W-1:0]  csum_add;

   pixel_op #(
      .DATA_W (DATA_W),
      .THRESH (THRESH)
   ) u_pixel_op (
      .mode (mode_reg),
      .x    (r_data),
      .y    (pix_y)
   );

   assign csum_add = csum_reg + w_data_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= ST_HDR;
         mode_reg      <= MODE_PASS;
         cnt_reg       <= '0;
         csum_reg      <= '0;
         w_data_reg    <= '0;
         frame_cnt_reg <= '0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mode_reg      <= mode_next;
         cnt_reg       <= cnt_next;
         csum_reg      <= csum_next;
         w_data_reg    <= w_data_next;
         frame_cnt_reg <= frame_cnt_next;
         err_reg       <= err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      mode_next      = mode_reg;
      cnt_next       = cnt_reg;
      csum_next      = csum_reg;
      w_data_next    = w_data_reg;
      frame_cnt_next = frame_cnt_reg;
      err_next       = err_reg;
      rd_uart        = 1'b0;
      wr_uart        = 1'b0;
      // Strobes are combinational from the FIFO flags, so reset must also
      // silence them immediately rather than at the next edge.
      if (en && !reset) begin
         case (state_reg)
            ST_HDR: if (!rx_empty) begin
               rd_uart = 1'b1;
               if ((r_data & RSVD) != '0) begin
                  err_next = 1'b1;     // word dropped, stay in HDR
               end else begin
                  mode_next  = r_data[1:0];
                  state_next = ST_LEN;
               end
            end
            ST_LEN: if (!rx_empty) begin
               rd_uart    = 1'b1;
               cnt_next   = (r_data == '0) ? {1'b1, {DATA_W{1'b0}}} : {1'b0, r_data};
               csum_next  = '0;
               state_next = ST_PIX;
            end
            ST_PIX: if (!rx_empty) begin
               rd_uart     = 1'b1;
               w_data_next = pix_y;
               state_next  = ST_OUT;
            end
            ST_OUT: if (!tx_full) begin
               wr_uart   = 1'b1;
               csum_next = csum_add;
               cnt_next  = cnt_reg - CW'(1);
               if (cnt_reg == CW'(1)) begin
                  // Preload the final checksum so SUM also drives w_data
                  // straight from the output register.
                  w_data_next = csum_add;
                  state_next  = ST_SUM;
               end else begin
                  state_next = ST_PIX;
               end
            end
            ST_SUM: if (!tx_full) begin
               wr_uart        = 1'b1;
               frame_cnt_next = frame_cnt_reg + CNT_W'(1);
               state_next     = ST_HDR;
            end
            default: state_next = ST_HDR;
         endcase
      end
   end

   assign w_data    = w_data_reg;
   assign busy      = (state_reg != ST_HDR);
   assign mode      = mode_reg;
   assign frame_cnt = frame_cnt_reg;
   assign err       = err_reg;

endmodule
